// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID register (PC, imem req/ready handshake, branch redirect, load-use stall).
// Optional macro FETCH_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    input  logic        read_en_ex,
    input  logic [31:0] instr_reg_ex,
    output logic [31:0] instr_reg,
    output logic [63:0] pc_reg,
    output logic        if_id_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        id_ex_bubble
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d, pcreg_q, pcreg_d, skid_pc_q, skid_pc_d, redir_q, redir_d, tgt;
    logic [31:0] instr_q, instr_d, skid_q, skid_d;
    logic        valid_q, valid_d, started_q, load_use, branch, fire;
    logic [4:0]  rd_ex;
    logic        unused_ex;

    assign unused_ex    = ^instr_reg_ex[31:5];
    assign rd_ex        = instr_reg_ex[4:0];
    assign load_use     = read_en_ex & valid_q & (rd_ex != 5'd31) &
                          (rd_ex == instr_q[9:5] | rd_ex == instr_q[20:16] | rd_ex == instr_q[4:0]);
    assign branch       = br_taken & ~load_use;
    assign tgt          = br_target & ~64'h3;
    assign imem_req     = started_q & (state_q != HOLD);
    assign fire         = imem_req & imem_ready;
    assign imem_addr    = pc_q;
    assign instr_reg    = instr_q;
    assign pc_reg       = pcreg_q;
    assign if_id_valid  = valid_q;
    assign id_ex_bubble = load_use;

    // Next-state: IF/ID is consumed (refilled with NOP) unless stalled; states handle redirect/skid/discard
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pcreg_d   = pcreg_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        redir_d   = redir_q;
        instr_d   = load_use ? instr_q : NOP_INSTR;
        valid_d   = load_use & valid_q;
        case (state_q)
            FETCH: begin
                if (branch) begin
                    redir_d = tgt;
                    if (imem_req & ~imem_ready) state_d = DISCARD;
                    else pc_d = tgt;
                end else if (fire) begin
                    pc_d = pc_q + 64'd4;
                    if (load_use) begin
                        skid_d    = imem_rdata;
                        skid_pc_d = pc_q;
                        state_d   = HOLD;
                    end else begin
                        instr_d = imem_rdata;
                        pcreg_d = pc_q;
                        valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (branch) begin
                    pc_d    = tgt;
                    state_d = FETCH;
                end else if (!load_use) begin
                    instr_d = skid_q;
                    pcreg_d = skid_pc_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                if (branch) redir_d = tgt;
                if (fire) begin
                    pc_d    = branch ? tgt : redir_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State registers with synchronous active-low reset; request enable rises one cycle after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            pcreg_q   <= '0;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            skid_q    <= NOP_INSTR;
            skid_pc_q <= '0;
            redir_q   <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pcreg_q   <= pcreg_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            skid_q    <= skid_d;
            skid_pc_q <= skid_pc_d;
            redir_q   <= redir_d;
            started_q <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of stall cycles and accepted redirects
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (load_use && stall_cnt != 32'hFFFFFFFF) stall_cnt <= stall_cnt + 32'd1;
            if (branch && flush_cnt != 32'hFFFFFFFF) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule
